// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared widths, PC constants, queue entry layout and occupancy classification
package fetch_stage_pkg;
  localparam int INSTR_W = 32;
  localparam int ADDR_W = 32;
  localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;
  localparam logic [ADDR_W-1:0] PC_R15_OFS = 32'd8;
  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  typedef struct packed {
    logic [INSTR_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;
  typedef enum logic [1:0] {OCC_EMPTY, OCC_PARTIAL, OCC_FULL} occ_t;
  function automatic occ_t occ_of(input logic [2:0] count, input logic [2:0] depth);
    return count == 3'd0 ? OCC_EMPTY : count == depth ? OCC_FULL : OCC_PARTIAL;
  endfunction
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO holding fetched {instruction, pc} pairs, with flush
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int W = 64
) (
  input logic clk,
  input logic reset,
  input logic push,
  input logic pop,
  input logic flush,
  input logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_N = (AW+1)'(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic do_pop, do_push;
  // a pop needs data; a push needs room, which a same-cycle pop provides
  always_comb begin
    do_pop = pop & (count != '0);
    do_push = push & ((count != FULL_N) | do_pop);
  end
  // flush only rewinds pointers; storage keeps its stale words until overwritten
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) mem[wr_ptr] <= din;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  assign dout = mem[rd_ptr];
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: owns fetch_pc, fills the prefetch queue from imem and hands entries to decode
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int QDEPTH = 2
) (
  input logic clk,
  input logic reset,
  output logic [ADDR_W-1:0] imem_addr,
  input logic [INSTR_W-1:0] imem_rd,
  input logic redirect_valid,
  input logic [ADDR_W-1:0] redirect_pc,
  output logic inst_valid,
  output logic [INSTR_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [ADDR_W-1:0] inst_pc8,
  input logic inst_ready,
  output logic [31:0] fetch_count
);
  localparam int CW = $clog2(QDEPTH) + 1;
  logic [ADDR_W-1:0] fetch_pc;
  logic [CW-1:0] count;
  logic push, pop;
  occ_t occ;
  fetch_entry_t head, entry;
  // handshake and fill decisions; a redirect suppresses the push of the wrong-path word
  always_comb begin
    occ = occ_of(3'(count), 3'(QDEPTH));
    inst_valid = occ != OCC_EMPTY;
    pop = inst_valid & inst_ready;
    push = ~redirect_valid & ((occ != OCC_FULL) | pop);
    entry.inst = imem_rd;
    entry.pc = fetch_pc;
  end
  // fetch address and accepted-instruction counter; a popped head still counts during a redirect
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC & ~32'h3;
      fetch_count <= '0;
    end else begin
      fetch_pc <= redirect_valid ? redirect_pc & ~32'h3 : push ? fetch_pc + PC_STEP : fetch_pc;
      fetch_count <= fetch_count + 32'(pop);
    end
  end
  fetch_queue #(.DEPTH(QDEPTH), .W(INSTR_W + ADDR_W)) u_queue (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .flush(redirect_valid),
    .din(entry),
    .dout(head),
    .count(count)
  );
  assign imem_addr = fetch_pc;
  assign inst = head.inst;
  assign inst_pc = head.pc;
  assign inst_pc8 = head.pc + PC_R15_OFS;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench driving QDEPTH=2 and QDEPTH=4 instances with identical stimulus
module tb_fetch_stage;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] pc8;
  } ent_t;
  typedef struct {
    int d;
    int s;
    logic [31:0] x;
  } chk_t;
  logic clk = 0, reset = 1, redirect_valid = 0, inst_ready = 0, done = 0;
  logic [31:0] redirect_pc = 0;
  logic [31:0] a2, rd2, i2, p2, p82, fc2, a4, rd4, i4, p4, p84, fc4;
  logic v2, v4;
  ent_t sb2[$], sb4[$], e, got;
  chk_t dq[$], c;
  logic [31:0] act;
  int checks = 0, failures = 0;
  string sname[6] = '{"valid", "inst", "inst_pc", "inst_pc8", "fetch_count", "imem_addr"};
  always #5 clk = ~clk;
  assign rd2 = a2 ^ 32'hE000_0000;
  assign rd4 = a4 ^ 32'hE000_0000;
  fetch_stage #(.QDEPTH(2)) dut2 (
    .clk(clk), .reset(reset), .imem_addr(a2), .imem_rd(rd2), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .inst_valid(v2), .inst(i2), .inst_pc(p2), .inst_pc8(p82),
    .inst_ready(inst_ready), .fetch_count(fc2)
  );
  fetch_stage #(.QDEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .imem_addr(a4), .imem_rd(rd4), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .inst_valid(v4), .inst(i4), .inst_pc(p4), .inst_pc8(p84),
    .inst_ready(inst_ready), .fetch_count(fc4)
  );
  function automatic logic [31:0] probe(input int d, input int s);
    case (s)
      0: return d == 0 ? {31'b0, v2} : {31'b0, v4};
      1: return d == 0 ? i2 : i4;
      2: return d == 0 ? p2 : p4;
      3: return d == 0 ? p82 : p84;
      4: return d == 0 ? fc2 : fc4;
      default: return d == 0 ? a2 : a4;
    endcase
  endfunction
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic expect_pc(input logic [31:0] pc);
    ent_t x;
    x.pc = pc;
    x.inst = pc ^ 32'hE000_0000;
    x.pc8 = pc + 32'd8;
    sb2.push_back(x);
    sb4.push_back(x);
  endtask
  task automatic want(input int d, input int s, input logic [31:0] x);
    chk_t k;
    k.d = d;
    k.s = s;
    k.x = x;
    dq.push_back(k);
  endtask
  task automatic want_both(input int s, input logic [31:0] x);
    want(0, s, x);
    want(1, s, x);
  endtask
  // monitor: drains directed checks, then scores every accepted head against the expected stream
  always @(negedge clk) begin
    while (dq.size() > 0) begin
      c = dq.pop_front();
      act = probe(c.d, c.s);
      checks++;
      if (act !== c.x) begin
        failures++;
        $display("FAIL q%0d_%s got=%h want=%h", c.d == 0 ? 2 : 4, sname[c.s], act, c.x);
      end
    end
    if (!reset && inst_ready) for (int d = 0; d < 2; d++) if (probe(d, 0) != 0) begin
      checks++;
      got.pc = probe(d, 2);
      got.inst = probe(d, 1);
      got.pc8 = probe(d, 3);
      if ((d == 0 ? sb2.size() : sb4.size()) == 0) begin
        failures++;
        $display("FAIL q%0d_pop unexpected pc=%h", d == 0 ? 2 : 4, got.pc);
      end else begin
        if (d == 0) e = sb2.pop_front();
        else e = sb4.pop_front();
        if (got.pc !== e.pc || got.inst !== e.inst || got.pc8 !== e.pc8) begin
          failures++;
          $display("FAIL q%0d_head got pc=%h inst=%h pc8=%h want pc=%h inst=%h pc8=%h",
                   d == 0 ? 2 : 4, got.pc, got.inst, got.pc8, e.pc, e.inst, e.pc8);
        end
      end
    end
    if (done) begin
      checks += 2;
      if (sb2.size() != 0) begin
        failures++;
        $display("FAIL q2_leftover got=%0d want=0", sb2.size());
      end
      if (sb4.size() != 0) begin
        failures++;
        $display("FAIL q4_leftover got=%0d want=0", sb4.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end
  initial begin
    step(2);
    want_both(0, 0); want_both(1, 0); want_both(2, 0);
    want_both(3, 8); want_both(4, 0); want_both(5, 0);
    reset = 0;
    inst_ready = 1;
    expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8); expect_pc(32'hC);
    step(5);
    inst_ready = 0;
    want_both(4, 4);
    want_both(2, 32'h10);
    reset = 1;
    redirect_valid = 1;
    redirect_pc = 32'h100;
    step(1);
    reset = 0;
    redirect_valid = 0;
    want_both(0, 0); want_both(5, 0); want_both(4, 0);
    step(5);
    want(0, 5, 32'h8);
    want(1, 5, 32'h10);
    want_both(0, 1);
    want_both(2, 0);
    expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8); expect_pc(32'hC);
    inst_ready = 1;
    step(3);
    redirect_valid = 1;
    redirect_pc = 32'h43;
    step(1);
    redirect_valid = 0;
    want_both(0, 0); want_both(5, 32'h40); want_both(4, 4);
    expect_pc(32'h40); expect_pc(32'h44); expect_pc(32'h48); expect_pc(32'h4C);
    step(1);
    want_both(2, 32'h40);
    want_both(1, 32'hE000_0040);
    step(3);
    redirect_valid = 1;
    redirect_pc = 32'hFFFF_FFF8;
    step(1);
    redirect_valid = 0;
    want_both(0, 0); want_both(5, 32'hFFFF_FFF8); want_both(4, 8);
    expect_pc(32'hFFFF_FFF8); expect_pc(32'hFFFF_FFFC); expect_pc(32'h0);
    step(1);
    want_both(3, 32'h0);
    step(3);
    inst_ready = 0;
    want_both(4, 11);
    want_both(2, 32'h4);
    step(2);
    done = 1;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end of the ARM core; sits directly upstream of the instruction memory.
- Owns the fetch PC and drives the imem word address; imem read data is combinational and returns in the same cycle.
- Captures each fetched word with its PC into a small prefetch queue.
- Presents queue entries to decode with a valid/ready handshake, and flushes the queue and refetches on a branch redirect from execute.

Parameters:
- RESET_PC, 32'h0000_0000: fetch address after reset; bits [1:0] must be 0.
- QDEPTH, 2: prefetch queue entries; legal values 2 or 4.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_addr  output  32  byte address to imem; equals fetch_pc; bits [1:0] always 0.
- imem_rd  input  32  instruction word from imem for imem_addr, same cycle.
- redirect_valid  input  1  branch taken or PC write; flush and refetch.
- redirect_pc  input  32  new fetch target; bits [1:0] are ignored and forced to 0.
- inst_valid  output  1  queue head holds a valid instruction.
- inst  output  32  instruction word at the queue head.
- inst_pc  output  32  address of inst.
- inst_pc8  output  32  inst_pc + 8, the architectural R15 value seen by that instruction.
- inst_ready  input  1  decode accepts the head this cycle.
- fetch_count  output  32  count of instructions accepted by decode, wrapping.

Behaviour:
- Reset (sync, on the clock edge with reset high):
  - fetch_pc = RESET_PC; count = 0; rd_ptr = wr_ptr = 0; all queue storage = 0; fetch_count = 0.
  - Hence inst_valid = 0, inst = 0, inst_pc = 0, inst_pc8 = 8.
  - Reset overrides every other input, including a redirect, and discards an in-flight queue.
- Occupancy states: EMPTY (count = 0), PARTIAL (0 < count < QDEPTH), FULL (count = QDEPTH).
  - inst_valid = (count != 0), driven from registers, not from imem_rd.
- pop = inst_valid & inst_ready. On pop: rd_ptr advances, modulo QDEPTH, and fetch_count increments.
- push = ~redirect_valid & (count < QDEPTH | pop).
  - On push: entry[wr_ptr] = {imem_rd, fetch_pc}; wr_ptr advances; fetch_pc = fetch_pc + 4.
  - Pop and push may occur in the same cycle when FULL: count is unchanged.
  - FULL without pop: no push, fetch_pc holds, imem_addr stable.
  - count update: count + push - pop.
- Redirect has highest priority after reset:
  - Next state: fetch_pc = {redirect_pc[31:2], 2'b00}; count = 0; rd_ptr = wr_ptr = 0; no push this cycle.
  - A pop in the same cycle still completes: fetch_count increments, since the head was consumed by decode.
  - Next cycle: inst_valid = 0 (one bubble); imem_addr = redirect target; push resumes.
  - First redirected instruction is visible to decode 2 cycles after redirect_valid was sampled.
- Latency, no stall: an instruction fetched in cycle N is inst_valid at cycle N+1.
  - Steady-state throughput is 1 instruction per cycle.
- Arithmetic: all PC sums are modulo 2^32.
  - fetch_pc 0xFFFF_FFFC + 4 = 0x0000_0000.
  - inst_pc8 for 0xFFFF_FFF8 = 0x0000_0000.
- Queue contents are never altered except by push, redirect, or reset. inst and inst_pc change only on pop, push-into-empty, redirect, or reset.
- inst_ready while inst_valid = 0 has no effect.

Decomposition:
- Shared include arm_defs.vh holds:
  - INSTR_W = 32, ADDR_W = 32, PC_STEP = 4, PC_R15_OFS = 8.
  - The default reset vector constant.
- One natural sub-module: fetch_queue.
  - Synchronous FIFO; width INSTR_W + ADDR_W, depth QDEPTH.
  - Ports push, pop, flush, din, dout, count; sync active-high reset.
- fetch_stage holds fetch_pc, push/pop/redirect priority logic, and fetch_count.

Test Plan:
- Bench imem model: RD = A ^ 32'hE000_0000.
- Reset release, inst_ready = 1:
  - Cycle 1: inst_valid = 1, inst = E000_0000, inst_pc = 0, inst_pc8 = 8.
  - Then inst_pc = 4, 8, 0xC on consecutive cycles; fetch_count = 4 after 4 pops.
- inst_ready = 0 for 5 cycles after reset:
  - count saturates at QDEPTH = 2; imem_addr holds at 8.
  - Raising ready delivers inst_pc 0, 4, 8 back-to-back with no gap and no duplicate.
- redirect_valid = 1 with redirect_pc = 0x0000_0043 while FULL and popping:
  - Next cycle inst_valid = 0 and imem_addr = 0x40.
  - Following cycle inst_pc = 0x40, inst = E000_0040.
  - fetch_count increments once for the popped head.
- Wrap: redirect to 0xFFFF_FFF8:
  - Delivered inst_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
  - inst_pc8 sequence 0000_0000, 0000_0004, 0000_0008.
- Reset asserted mid-stream together with redirect_valid = 1:
  - Next cycle inst_valid = 0, imem_addr = RESET_PC, fetch_count = 0.
  - The redirect is ignored.
- QDEPTH = 4 build:
  - Stall fills 4 entries; simultaneous push+pop when FULL keeps count = 4 and preserves in-order inst_pc.
